stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  N-channel, W-bit registered stream multiplexer; successor to the fixed 2:1 muxes.
//  - Valid/ready handshake on every input channel and on the output.
//  - Round-robin arbitration, held for a whole packet (until a beat with last=1 transfers).
//  - Registered output stage.
//  - Merges several producer streams into one consumer in the datapath.
// PARAMETERS
//  N   2   number of input channels (>=1)
//  W   9   data width per channel
//  CW  max(1,$clog2(N))   localparam: width of the channel index
// PORTS
//  clk        in   1      single clock; all logic rising-edge
//  rst        in   1      reset, asynchronous and active-high
//  in_data    in   N*W    channel i data = in_data[i*W +: W]
//  in_valid   in   N      per-channel beat valid
//  in_last    in   N      per-channel last beat of packet
//  in_ready   out  N      per-channel accept; at most one bit high
//  out_data   out  W      registered output data
//  out_valid  out  1      output beat valid
//  out_last   out  1      output last flag
//  out_ready  in   1      downstream accept
//  grant_idx  out  CW     currently/last granted channel
//  busy       out  1      1 while in LOCKED
// BEHAVIOUR
//  Reset values (async assert, clears immediately):
//   - out_data=0, out_valid=0, out_last=0, in_ready=0
//   - grant_idx=0, busy=0, rr_ptr=0, state=IDLE
//  Transfer definitions:
//   - input transfer: in_valid[g] & in_ready[g]
//   - output transfer: out_valid & out_ready
//  FSM IDLE:
//   - in_ready=0.
//   - If any in_valid: grant g = first valid channel scanning rr_ptr, rr_ptr+1, ... mod N.
//   - On that grant, register grant_idx=g and go to LOCKED next cycle. Else stay.
//  FSM LOCKED:
//   - in_ready[g] = ~out_valid | out_ready. All other in_ready bits = 0.
//   - On input transfer: out_data<=in_data[g], out_last<=in_last[g], out_valid<=1.
//   - Input transfer with in_last[g]=1: next state IDLE, rr_ptr<=(g+1) mod N (wraps N-1 -> 0).
//  Output register:
//   - Output transfer with no new load: out_valid<=0.
//   - Output transfer and load in the same cycle: new beat replaces old; no bubble.
//  Throughput: 1 beat/cycle in LOCKED while out_ready=1.
//  Latency: first beat of a packet reaches out_valid 2 cycles after in_valid rises in IDLE
//   (1 cycle arbitration + 1 cycle output register).
//  Packet gap: 1 idle cycle between packets, used for re-arbitration.
//  Stall: out_ready=0 with out_valid=1 holds out_data/out_last stable and forces in_ready=0.
//  in_valid[g] dropping mid-packet: stay LOCKED; no other channel is served.
//  Requests changing during LOCKED do not affect the grant.
//  Reset mid-packet:
//   - Packet is aborted and any pending output beat is discarded.
//   - Arbitration restarts from channel 0.
//  N=1: grant always 0; packets pass through with the same 2-cycle latency.
// CONFIGURATION
//  Macro STREAM_MUX_RR_FORCE_EN, when defined:
//   - Adds ports: force_en in 1, force_sel in CW.
//   - In IDLE with force_en=1: only channel force_sel may be granted; waits if it is not valid.
//     rr_ptr is still updated at packet end.
//   - force_en is ignored in LOCKED (never splits a packet).
//   - force_sel>=N: no grant.
//  When not defined: the ports are absent and arbitration is pure round-robin.
// TESTING (N=4, W=9 unless stated)
//  1. Reset: assert rst mid-cycle -> all outputs 0 immediately; after release with no
//     valid -> busy stays 0.
//  2. Single beat: ch2 sends 9'h1A5 with last=1, out_ready=1 -> out_data=9'h1A5,
//     out_last=1, out_valid on cycle 2; grant_idx=2; next winner scan starts at ch3.
//  3. Fairness: all 4 channels send 1-beat packets continuously -> grant order 0,1,2,3,0,...
//     (wrap checked); every packet forwarded exactly once.
//  4. Packet lock: ch1 sends 3-beat packet 9'h001,9'h002,9'h003 while ch0 is valid ->
//     three ch1 beats contiguous, then ch0.
//  5. Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data stable, in_ready=0;
//     no beat lost or duplicated; resumes at 1 beat/cycle.
//  6. Force (macro on): force_en=1, force_sel=3 with ch0..3 valid -> only ch3 granted;
//     force_sel=3 with ch3 idle -> no grant.

Source files
------------

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   N-channel, W-bit stream multiplexer with valid/ready handshakes on every
//   input channel and on the output. Channels are arbitrated round-robin. The
//   winner keeps the grant until the beat carrying last=1 transfers. The output
//   beat is held in a register.
//
//   Optional build macro: STREAM_MUX_RR_FORCE_EN
//     When it is defined, the force_en/force_sel ports exist. While the mux is
//     idle and force_en=1, only channel force_sel may win arbitration. A
//     force_sel value >= N grants no channel.
//
// Parameters
//   N   number of input channels (>= 1)
//   W   data width per channel
//   CW  width of the channel index, max(1, $clog2(N)); derived, not settable
//
// Ports
//   clk        single clock; all logic on the rising edge
//   rst        asynchronous, active-high reset
//   in_data    N*W  channel i data = in_data[i*W +: W]
//   in_valid   N    per-channel beat valid
//   in_last    N    per-channel last beat of a packet
//   in_ready   N    per-channel accept; at most one bit is high
//   out_data   W    registered output data
//   out_valid  1    output beat valid
//   out_last   1    output last flag
//   out_ready  1    downstream accept
//   grant_idx  CW   channel that holds the grant now, or held it last
//   busy       1    high while a packet is locked to a channel
//   force_en   1    (macro only) restrict the next grant to force_sel
//   force_sel  CW   (macro only) channel allowed to win while force_en=1
// -----------------------------------------------------------------------------
module stream_mux_rr #(
  parameter  int N  = 2,
  parameter  int W  = 9,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
`ifdef STREAM_MUX_RR_FORCE_EN
  input  logic            force_en,
  input  logic [CW-1:0]   force_sel,
`endif
  output logic [CW-1:0]   grant_idx,
  output logic            busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_next;
  logic [CW-1:0] rr_ptr, rr_ptr_next;
  logic [CW-1:0] grant_next;
  logic [N-1:0]  req;
  logic          found;
  logic [CW-1:0] pick;
  logic [W-1:0]  sel_data;
  logic          sel_valid;
  logic          sel_last;
  logic          can_load;
  logic          in_xfer;

  // (base + off) mod N, where base < N and off < N.
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return CW'(s);
  endfunction

  // Channels that may compete in the next arbitration.
`ifdef STREAM_MUX_RR_FORCE_EN
  always_comb begin
    req = in_valid;
    if (force_en) begin
      req = '0;
      // If force_sel names no existing channel, nothing is requested.
      for (int i = 0; i < N; i++)
        if (force_sel == CW'(i)) req[i] = in_valid[i];
    end
  end
`else
  assign req = in_valid;
`endif

  // Round-robin pick: the first requester found scanning from rr_ptr upward.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_idx(rr_ptr, k)]) begin
        found = 1'b1;
        pick  = wrap_idx(rr_ptr, k);
      end
    end
  end

  // Signals of the channel that holds the grant.
  assign sel_data  = in_data[int'(grant_idx)*W +: W];
  assign sel_valid = in_valid[grant_idx];
  assign sel_last  = in_last[grant_idx];

  // The output register can take a beat if it is empty, or if its beat leaves
  // in this same cycle.
  assign can_load  = ~out_valid | out_ready;

  // NOTE: every signal assigned here gets a default value first. Without the
  // defaults, a path that does not assign a signal would infer a latch.
  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    grant_next  = grant_idx;
    in_ready    = '0;
    in_xfer     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        in_ready[grant_idx] = can_load;
        in_xfer             = can_load & sel_valid;
        if (in_xfer && sel_last) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_idx == CW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the sequential state uses non-blocking assignments only. Every
  // register then samples values from before the clock edge, whatever order
  // the statements run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_ptr_next;
      grant_idx <= grant_next;
      // A new beat overwrites a beat leaving in the same cycle, so no bubble.
      if (in_xfer) begin
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
  localparam int N  = 4;
  localparam int W  = 9;
  localparam int CW = 2;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_last, out_ready;
  logic [CW-1:0]  grant_idx;
  logic           busy;
`ifdef STREAM_MUX_RR_FORCE_EN
  logic           force_en  = 1'b0;
  logic [CW-1:0]  force_sel = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int model_rr = 0;  // model's round-robin pointer
  int dseq     = 0;  // running tag that makes every payload unique

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         first;
  } beat_t;

  // One table record: packets queued per channel, beats per packet, the
  // expected packet grant order and the backpressure mode.
  typedef struct {
    int np[N];
    int pl[N];
    int ord[8];
    int n_ord;
    int mode;  // 0: always ready, 1: random ready + valid gaps, 2: 5-cycle stall
  } vec_t;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
`ifdef STREAM_MUX_RR_FORCE_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration at packet level: from the pointer, serve the first
  // channel that still has a packet, then move the pointer one past it.
  task automatic rr_model(input int np[N], output int ord[$]);
    int  left[N];
    int  ptr;
    bit  any;
    left = np;
    ptr  = model_rr;
    ord.delete();
    do begin
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (left[c] > 0) begin
          ord.push_back(c);
          left[c]--;
          ptr = (c + 1) % N;
          any = 1'b1;
          break;
        end
      end
    end while (any);
  endtask

  // Queue the packets on all channels at once and drive them. Every output
  // beat is compared with the beat sequence that the packet order implies.
  task automatic run_phase(input int np[N], input int pl[N], input int ord[$], input int mode);
    beat_t        src[N][$];
    beat_t        exp_q[$];
    beat_t        b;
    int           pos[N];
    int           cyc, bubbles, outs, remaining;
    logic         stall_prev;
    logic [W-1:0] held_d;
    logic         held_l;

    for (int c = 0; c < N; c++) begin
      pos[c] = 0;
      for (int p = 0; p < np[c]; p++)
        for (int bi = 0; bi < pl[c]; bi++) begin
          b.data  = W'(c * 128 + (dseq % 128));
          dseq++;
          b.last  = (bi == pl[c] - 1);
          b.first = (bi == 0);
          src[c].push_back(b);
        end
    end
    foreach (ord[i]) begin
      int c;
      c = ord[i];
      forever begin
        if (pos[c] >= src[c].size()) break;
        exp_q.push_back(src[c][pos[c]]);
        pos[c]++;
        if (exp_q[$].last) break;
      end
    end

    cyc = 0; bubbles = 0; outs = 0; stall_prev = 1'b0; held_d = '0; held_l = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 5 && cyc < 10);
      endcase
      for (int c = 0; c < N; c++) begin
        if (src[c].size() > 0) begin
          in_data[c*W +: W] = src[c][0].data;
          in_last[c]        = src[c][0].last;
          // A packet's first beat is always offered. Later beats may drop out.
          in_valid[c]       = src[c][0].first || (mode != 1) || ($urandom_range(0, 3) != 0);
        end else begin
          in_data[c*W +: W] = '0;
          in_last[c]        = 1'b0;
          in_valid[c]       = 1'b0;
        end
      end
      #3;
      check("in_ready_rule", 32'(in_ready),
            32'((busy && (!out_valid || out_ready)) ? (4'b0001 << grant_idx) : 4'b0000));
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", {22'd0, out_last, out_data}, {22'd0, held_l, held_d});
      end
      if (out_valid && out_ready) begin
        check("out_beat", {22'd0, out_last, out_data}, {22'd0, exp_q[0].last, exp_q[0].data});
        void'(exp_q.pop_front());
        outs++;
      end else if (outs > 0 && !out_valid) begin
        bubbles++;
      end
      stall_prev = out_valid && !out_ready;
      held_d     = out_data;
      held_l     = out_last;
      for (int c = 0; c < N; c++)
        if (in_valid[c] && in_ready[c]) void'(src[c].pop_front());
      cyc++;
      if (cyc > 1000) begin
        check("phase_timeout", 32'(exp_q.size()), 32'd0);
        break;
      end
    end
    @(negedge clk);
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    remaining = 0;
    for (int c = 0; c < N; c++) remaining += src[c].size();
    check("inputs_drained", 32'(remaining), 32'd0);
    if (mode == 2) check("no_bubbles", 32'(bubbles), 32'd0);
    if (ord.size() > 0) model_rr = (ord[$] + 1) % N;
  endtask

  vec_t tbl[6];
  int   ord[$];
  int   np[N];
  int   pl[N];
  int   tot;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{'{2, 2, 2, 2}, '{1, 1, 1, 1}, '{0, 1, 2, 3, 0, 1, 2, 3}, 8, 0};
    tbl[1] = '{'{1, 0, 0, 0}, '{2, 1, 1, 1}, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, 0};
    tbl[2] = '{'{1, 1, 0, 0}, '{1, 3, 1, 1}, '{1, 0, 0, 0, 0, 0, 0, 0}, 2, 0};
    tbl[3] = '{'{0, 1, 0, 1}, '{1, 2, 1, 2}, '{1, 3, 0, 0, 0, 0, 0, 0}, 2, 0};
    tbl[4] = '{'{1, 0, 1, 1}, '{1, 1, 1, 1}, '{0, 2, 3, 0, 0, 0, 0, 0}, 3, 0};
    tbl[5] = '{'{0, 1, 0, 0}, '{1, 8, 1, 1}, '{1, 0, 0, 0, 0, 0, 0, 0}, 1, 2};

    rst = 1'b1; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    #1;
    check("por_out_valid", 32'(out_valid), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single beat on ch2: 2-cycle latency, grant 2.
    @(negedge clk);
    in_data[2*W +: W] = 9'h1A5; in_valid = 4'b0100; in_last = 4'b0100; out_ready = 1'b1;
    @(negedge clk);
    check("lat_c1_out_valid", 32'(out_valid), 32'd0);
    check("lat_c1_busy", 32'(busy), 32'd1);
    check("lat_c1_grant", 32'(grant_idx), 32'd2);
    check("lat_c1_in_ready", 32'(in_ready), 32'b0100);
    @(negedge clk);
    check("lat_c2_out_valid", 32'(out_valid), 32'd1);
    check("lat_c2_out_data", 32'(out_data), 32'h1A5);
    check("lat_c2_out_last", 32'(out_last), 32'd1);
    check("lat_c2_busy", 32'(busy), 32'd0);
    in_valid = '0; in_last = '0; in_data = '0;
    @(negedge clk);
    check("lat_c3_out_valid", 32'(out_valid), 32'd0);

    // ch3 has priority now (pointer moved to 3). Start a packet, stall the
    // output, then reset in the middle of a cycle.
    in_data[3*W +: W] = 9'h0AA; in_valid = 4'b1000; in_last = 4'b0000; out_ready = 1'b0;
    @(negedge clk);
    check("abort_grant", 32'(grant_idx), 32'd3);
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd1);
    check("abort_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    in_valid = '0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);
    end

    // Table: fairness and wrap, packet lock, pointer moves, stall mid-packet.
    for (int t = 0; t < 6; t++) begin
      ord.delete();
      for (int i = 0; i < tbl[t].n_ord; i++) ord.push_back(tbl[t].ord[i]);
      run_phase(tbl[t].np, tbl[t].pl, ord, tbl[t].mode);
    end

    // Randomized: random packet counts/lengths, valid gaps, random out_ready.
    for (int r = 0; r < 10; r++) begin
      tot = 0;
      for (int c = 0; c < N; c++) begin
        np[c] = $urandom_range(0, 3);
        pl[c] = $urandom_range(1, 4);
        tot  += np[c];
      end
      if (tot == 0) np[r % N] = 1;
      rr_model(np, ord);
      run_phase(np, pl, ord, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
